// File: rtl/isa_pkg.sv
// isa_pkg: shared ISA definitions for the instruction encoder and the decoder bench.
//   Opcode constants, instruction format codes, the field tuple payload struct,
//   enc_word() which packs a tuple into a 16-bit ISA word, and fields_clear()
//   which reports whether the fields a format does not encode are all zero.
package isa_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned IMM_W  = 8;
  localparam int unsigned WORD_W = 16;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_SRL = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_LI  = 4'h8;
  localparam logic [3:0] OP_LW  = 4'h9;
  localparam logic [3:0] OP_SW  = 4'hA;
  localparam logic [3:0] OP_BIZ = 4'hB;
  localparam logic [3:0] OP_BNZ = 4'hC;
  localparam logic [3:0] OP_JAL = 4'hD;
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_JR  = 4'hF;

  // FMT_R {op,dr,sa,sb}; FMT_I {op,dr,imm}; FMT_B {op,sa,imm}; FMT_J {op,dr,sa,0}
  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_B = 2'd2;
  localparam logic [1:0] FMT_J = 2'd3;

  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] dr;
    logic [REG_W-1:0] sa;
    logic [REG_W-1:0] sb;
    logic [IMM_W-1:0] imm;
  } fields_t;

  function automatic logic [1:0] op_fmt(input logic [3:0] op);
    logic [1:0] fmt;
    fmt = FMT_R;
    case (op)
      OP_LI, OP_JAL, OP_JMP: fmt = FMT_I;
      OP_BIZ, OP_BNZ:        fmt = FMT_B;
      OP_JR:                 fmt = FMT_J;
      default:               fmt = FMT_R;
    endcase
    return fmt;
  endfunction

  // Fields not placed in the word by the opcode's format are dropped (forced to 0).
  function automatic logic [15:0] enc_word(input logic [3:0] op, input logic [3:0] dr,
                                           input logic [3:0] sa, input logic [3:0] sb,
                                           input logic [7:0] imm);
    logic [15:0] w;
    w = 16'h0000;
    case (op_fmt(op))
      FMT_I:   w = {op, dr, imm};
      FMT_B:   w = {op, sa, imm};
      FMT_J:   w = {op, dr, sa, 4'h0};
      default: w = {op, dr, sa, sb};
    endcase
    return w;
  endfunction

  // True when every register field the format does not encode is zero.
  // The immediate is not inspected for register formats.
  function automatic logic fields_clear(input logic [3:0] op, input logic [3:0] dr,
                                        input logic [3:0] sa, input logic [3:0] sb);
    logic ok;
    ok = 1'b1;
    case (op_fmt(op))
      FMT_I:   ok = (sa == 4'h0) && (sb == 4'h0);
      FMT_B:   ok = (dr == 4'h0) && (sb == 4'h0);
      FMT_J:   ok = (sb == 4'h0);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// enc_fifo: synchronous FIFO buffering encoded words between field input and
//   the memory write port. Combinational head read, full/empty flags, flush.
// Ports:
//   clk, rst      clock, async active-high reset
//   flush         empties the FIFO at the next edge (has priority over push/pop)
//   push, wdata   write an entry (ignored when full unless popped the same cycle)
//   pop, rdata    remove the head entry; rdata is the current head
//   full, empty   fill status
module enc_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign rdata     = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 16-bit ISA words and
//   streams them to instruction memory at sequential addresses from BASE_ADDR.
//   Used by the boot/test loader; an enc_fifo absorbs memory write stalls.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, finish            session control pulses (start wins)
//   in_valid/in_ready        field tuple handshake (in_ready combinational)
//   opcode,dr,sa,sb,immediate  field tuple
//   mem_we/mem_ready         memory write handshake; mem_addr/mem_wdata held until accepted
//   busy, done, overflow     session status; fmt_err pulses on a rejected tuple
// Build option: define ENC_FIELD_CHECK_EN to reject tuples whose unencoded
//   fields are nonzero; otherwise those fields are silently dropped and
//   fmt_err is tied low.
module instr_encoder #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [3:0]        dr,
  input  logic [3:0]        sa,
  input  logic [3:0]        sb,
  input  logic [7:0]        immediate,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              fmt_err
);

  import isa_pkg::*;

  localparam int unsigned       CNT_W   = $clog2(MEM_DEPTH + 1);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(BASE_ADDR + MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MEM_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_busy;
  logic              r_done;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_push_cnt;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_wdata;

  fields_t           w_fields;
  logic [15:0]       w_word;
  logic              w_fields_ok;
  logic              w_accept;
  logic              w_cap_hit;
  logic              w_push;
  logic              w_ovf_set;
  logic              w_wr_pending;
  logic              w_wr_done;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [15:0]       w_fifo_rdata;

  assign w_fields = '{opcode: opcode, dr: dr, sa: sa, sb: sb, imm: immediate};
  assign w_word   = enc_word(w_fields.opcode, w_fields.dr, w_fields.sa, w_fields.sb, w_fields.imm);

`ifdef ENC_FIELD_CHECK_EN
  logic r_fmt_err;

  assign w_fields_ok = fields_clear(w_fields.opcode, w_fields.dr, w_fields.sa, w_fields.sb);
  assign fmt_err     = r_fmt_err;

  // One-cycle pulse for each consumed-but-rejected tuple
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fmt_err <= 1'b0;
    else     r_fmt_err <= w_accept & ~w_fields_ok;
  end
`else
  assign w_fields_ok = 1'b1;
  assign fmt_err     = 1'b0;
`endif

  // in_ready follows the current fill level only, even if a pop is due this cycle.
  assign in_ready  = (r_state == S_LOAD) & ~w_fifo_full;
  assign w_accept  = in_valid & in_ready;
  assign w_cap_hit = (r_push_cnt == CNT_MAX);
  // A tuple accepted in the same cycle as start is lost with the flush.
  assign w_push    = w_accept & w_fields_ok & ~w_cap_hit & ~start;
  assign w_ovf_set = w_accept & w_fields_ok & w_cap_hit;

  // Popping on the completing edge keeps one word per cycle with mem_ready high.
  assign w_wr_pending = r_mem_we & ~mem_ready;
  assign w_wr_done    = r_mem_we & mem_ready;
  assign w_pop        = ~w_fifo_empty & ~w_wr_pending & ~start;

  enc_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start),
    .push  (w_push),
    .wdata (w_word),
    .pop   (w_pop),
    .rdata (w_fifo_rdata),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD:  if (finish) w_state_nxt = S_DRAIN;
        S_DRAIN: if (w_fifo_empty && !r_mem_we) w_state_nxt = S_DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // State register with registered status decodes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_DRAIN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Session word count and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_push_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (start) begin
      r_push_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)    r_push_cnt <= r_push_cnt + CNT_W'(1);
      if (w_ovf_set) r_overflow <= 1'b1;
    end
  end

  // Memory write port; address saturates at the last writable word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= BASE;
      r_mem_wdata <= 16'h0000;
    end else if (start) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= BASE;
    end else begin
      if (w_wr_done && (r_mem_addr != LAST)) r_mem_addr <= r_mem_addr + ADDR_W'(1);
      if (w_pop) begin
        r_mem_we    <= 1'b1;
        r_mem_wdata <= w_fifo_rdata;
      end else if (w_wr_done) begin
        r_mem_we    <= 1'b0;
      end
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder. The driver predicts
//   each memory write (address, word) with an arithmetic model of the ISA
//   formats and queues it; a monitor pops and compares on every completed write
//   and checks that stalled writes hold address and data.
module tb_instr_encoder;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned BASE   = 0;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned FDEPTH = 4;

  logic              clk = 1'b0;
  logic              rst, start, finish, in_valid, in_ready;
  logic [3:0]        opcode, dr, sa, sb;
  logic [7:0]        immediate;
  logic              mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              busy, done, overflow, fmt_err;

  always #5 clk = ~clk;

  instr_encoder #(
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (BASE),
    .MEM_DEPTH  (DEPTH),
    .FIFO_DEPTH (FDEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .finish    (finish),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .dr        (dr),
    .sa        (sa),
    .sb        (sb),
    .immediate (immediate),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .fmt_err   (fmt_err)
  );

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   sess_cnt = 0;
  bit   exp_ovf = 1'b0;
  int   mode    = 0;  // mem_ready: 0 low, 1 high, 2 random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word value from the ISA layout: four nibbles, or nibble-nibble-byte.
  function automatic int model_word(int op, int d, int a, int b, int imm);
    if (op <= 7 || op == 9 || op == 10) return op * 4096 + d * 256 + a * 16 + b;
    if (op == 8 || op == 13 || op == 14) return op * 4096 + d * 256 + imm;
    if (op == 11 || op == 12)            return op * 4096 + a * 256 + imm;
    return op * 4096 + d * 256 + a * 16;
  endfunction

  function automatic bit model_reject(int op, int d, int a, int b);
`ifdef ENC_FIELD_CHECK_EN
    if (op == 8 || op == 13 || op == 14) return (a != 0) || (b != 0);
    if (op == 11 || op == 12)            return (d != 0) || (b != 0);
    if (op == 15)                        return (b != 0);
    return 1'b0;
`else
    return (op < 0) && (d < 0) && (a < 0) && (b < 0);
`endif
  endfunction

  // mem_ready driver: the only writer of mem_ready
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       mem_ready = 1'b0;
        1:       mem_ready = 1'b1;
        default: mem_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic monitor();
    bit          pend = 1'b0;
    logic [7:0]  paddr;
    logic [15:0] pdata;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
        continue;
      end
      if (pend) begin
        chk("hold_we", 32'(mem_we), 32'd1);
        chk("hold_addr_data", 32'({mem_addr, mem_wdata}), 32'({paddr, pdata}));
      end
      pend = 1'b0;
      if (mem_we && !start) begin
        if (!mem_ready) begin
          pend  = 1'b1;
          paddr = mem_addr;
          pdata = mem_wdata;
        end else if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", mem_addr, mem_wdata);
        end else begin
          e = q.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e.addr));
          chk("wr_data", 32'(mem_wdata), 32'(e.data));
        end
      end
    end
  endtask

  // Offer one tuple until accepted; predicts the resulting write.
  task automatic send(input int op, input int d, input int a, input int b, input int imm);
    int guard = 0;
    bit ok    = 1'b0;
    bit rej;
    opcode = 4'(op); dr = 4'(d); sa = 4'(a); sb = 4'(b); immediate = 8'(imm);
    in_valid = 1'b1;
    while (!ok && guard < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
        guard++;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
      in_valid = 1'b0;
      return;
    end
    rej = model_reject(op, d, a, b);
    if (!rej) begin
      if (sess_cnt < int'(DEPTH)) begin
        q.push_back('{int'(BASE) + sess_cnt, model_word(op, d, a, b, imm)});
        sess_cnt++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("fmt_err", 32'(fmt_err), 32'(rej));
  endtask

  task automatic send_rand_r();
    send($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
         $urandom_range(0, 15), $urandom_range(0, 255));
  endtask

  task automatic pulse_start();
    int saved = mode;
    mode = 0;
    @(posedge clk);
    #2;
    start = 1'b1;
    @(posedge clk);
    q.delete();
    sess_cnt = 0;
    exp_ovf  = 1'b0;
    #1;
    start = 1'b0;
    mode  = saved;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    @(posedge clk);
    #1;
    finish = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("done", 32'(done), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("in_ready_done", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    opcode = '0; dr = '0; sa = '0; sb = '0; immediate = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'(BASE));
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_fmt_err", 32'(fmt_err), 32'd0);
    @(posedge clk);
    #1;

    // ADD with first-write latency
    mode = 1;
    pulse_start();
    @(negedge clk);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    send(0, 1, 2, 3, 8'h5A);
    chk("lat_we_accept_edge", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_we_next_edge", 32'(mem_we), 32'd1);
    chk("add_word", 32'(mem_wdata), 32'h0123);

    // LI then BIZ, then JR with nonzero sb
    pulse_start();
    send(8, 4, 0, 0, 8'hA5);
    send(11, 7, 5, 0, 8'h10);
    send(15, 2, 3, 9, 0);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: one word in the write register plus a full FIFO
    mode = 0;
    pulse_start();
    repeat (FDEPTH + 1) send_rand_r();
    opcode = 4'h3; dr = 4'h6; sa = 4'h7; sb = 4'h8; immediate = 8'h00;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_addr", 32'(mem_addr), 32'(BASE));
      @(posedge clk);
      #1;
    end
    mode = 1;
    send(3, 6, 7, 8, 0);
    pulse_finish();
    wait_done();

    // Overflow: more tuples than MEM_DEPTH
    mode = 2;
    pulse_start();
    repeat (DEPTH + 3) send_rand_r();
    pulse_finish();
    wait_done();
    pulse_start();
    @(negedge clk);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;

    // start during DRAIN with words queued
    mode = 0;
    repeat (3) send_rand_r();
    pulse_finish();
    @(negedge clk);
    chk("drain_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    pulse_start();
    chk("flush_mem_we", 32'(mem_we), 32'd0);
    chk("flush_mem_addr", 32'(mem_addr), 32'(BASE));
    mode = 1;
    send_rand_r();
    pulse_finish();
    wait_done();

    // Asynchronous reset mid-write
    pulse_start();
    mode = 0;
    repeat (2) send_rand_r();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_mem_we", 32'(mem_we), 32'd0);
    chk("arst_mem_addr", 32'(mem_addr), 32'(BASE));
    chk("arst_busy", 32'(busy), 32'd0);
    q.delete();
    sess_cnt = 0;
    exp_ovf  = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    mode = 1;
    pulse_start();
    send_rand_r();
    pulse_finish();
    wait_done();

    // Random sessions with random stalls, gaps and all opcodes
    for (int s = 0; s < 6; s++) begin
      mode = 2;
      pulse_start();
      for (int n = $urandom_range(1, 12); n > 0; n--) begin
        send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 1) * $urandom_range(0, 15), $urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      pulse_finish();
      wait_done();
    end

    repeat (5) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
